// File: rtl/meas_result_averager_pkg.sv
// Shared definitions for the measurement result path: state encoding and width helpers.
package meas_pkg;

  localparam int unsigned COUNT_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StAccum = 2'd1;
  localparam state_t StHold  = 2'd2;

  function automatic int unsigned signed_w(input int unsigned count_w);
    return count_w + 1;
  endfunction

  // Wide enough that summing 2**avg_log2 signed samples can never overflow.
  function automatic int unsigned acc_w(input int unsigned count_w, input int unsigned avg_log2);
    return count_w + 1 + avg_log2;
  endfunction

endpackage

// File: rtl/meas_result_averager_if.sv
// Sample-in / result-out bundle of the averager. Optional min/max signals exist only with
// MEAS_MINMAX_EN defined.
interface meas_result_averager_if
  import meas_pkg::*;
#(
  parameter int unsigned COUNT_W  = COUNT_W_DEF,
  parameter int unsigned AVG_LOG2 = 2
);
  logic                      sample_valid_i;
  logic [COUNT_W-1:0]        sample_count_i;
  logic                      sample_sign_i;
  logic                      clear_i;
  logic                      result_ready_i;
  logic                      result_valid_o;
  logic signed [COUNT_W:0]   result_data_o;
  logic                      overrange_o;
  logic                      overrun_o;
  logic [AVG_LOG2:0]         sample_cnt_o;
`ifdef MEAS_MINMAX_EN
  logic signed [COUNT_W:0]   result_min_o;
  logic signed [COUNT_W:0]   result_max_o;
`endif

  modport master (
    output sample_valid_i, sample_count_i, sample_sign_i, clear_i, result_ready_i,
    input  result_valid_o, result_data_o, overrange_o, overrun_o, sample_cnt_o
`ifdef MEAS_MINMAX_EN
    , input result_min_o, result_max_o
`endif
  );

  modport slave (
    input  sample_valid_i, sample_count_i, sample_sign_i, clear_i, result_ready_i,
    output result_valid_o, result_data_o, overrange_o, overrun_o, sample_cnt_o
`ifdef MEAS_MINMAX_EN
    , output result_min_o, result_max_o
`endif
  );

endinterface

// File: rtl/meas_result_averager_minmax.sv
// Tracks the smallest and largest signed sample of a window and registers them on window close.
module meas_minmax_tracker #(
  parameter int unsigned WIDTH = 17
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    first_i,
  input  logic                    add_i,
  input  logic                    commit_i,
  input  logic signed [WIDTH-1:0] sample_i,
  output logic signed [WIDTH-1:0] result_min_o,
  output logic signed [WIDTH-1:0] result_max_o
);

  logic signed [WIDTH-1:0] run_min_q, run_max_q, res_min_q, res_max_q;
  logic signed [WIDTH-1:0] new_min, new_max;

  always_comb begin
    new_min = (first_i || (sample_i < run_min_q)) ? sample_i : run_min_q;
    new_max = (first_i || (sample_i > run_max_q)) ? sample_i : run_max_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_min_q <= '0;
      run_max_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
    end else if (clear_i) begin
      run_min_q <= '0;
      run_max_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
    end else if (first_i || add_i) begin
      run_min_q <= new_min;
      run_max_q <= new_max;
      if (commit_i) begin
        res_min_q <= new_min;
        res_max_q <= new_max;
      end
    end
  end

  assign result_min_o = res_min_q;
  assign result_max_o = res_max_q;

endmodule

// File: rtl/meas_result_averager.sv
// Averages 2**AVG_LOG2 signed conversions and holds the result behind valid/ready.
// Optional feature macro: MEAS_MINMAX_EN adds per-window min/max outputs.
module meas_result_averager
  import meas_pkg::*;
#(
  parameter int unsigned        COUNT_W   = COUNT_W_DEF,
  parameter int unsigned        AVG_LOG2  = 2,
  parameter logic [COUNT_W-1:0] OVR_LIMIT = COUNT_W'(16'hFFF0)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  meas_result_averager_if.slave bus
);

  localparam int unsigned       SignedW = signed_w(COUNT_W);
  localparam int unsigned       AccW    = acc_w(COUNT_W, AVG_LOG2);
  localparam logic [AVG_LOG2:0] LastCnt = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  state_t                    state_q, state_d;
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic [AVG_LOG2:0]         cnt_q, cnt_d;
  logic                      win_ovr_q, win_ovr_d;
  logic signed [SignedW-1:0] result_q, result_d;
  logic                      ovr_q, ovr_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;

  logic signed [SignedW-1:0] smp;
  logic signed [AccW-1:0]    smp_ext, win_sum, avg_full;
  logic                      smp_ovr, win_ovr_n;
  logic                      first, add, last;

  // Negating zero yields zero, so -0 never appears.
  assign smp     = bus.sample_sign_i ? -$signed({1'b0, bus.sample_count_i})
                                     :  $signed({1'b0, bus.sample_count_i});
  assign smp_ext = AccW'(smp);
  assign smp_ovr = (bus.sample_count_i >= OVR_LIMIT);

  assign win_sum   = first ? smp_ext : (acc_q + smp_ext);
  assign win_ovr_n = first ? smp_ovr : (win_ovr_q | smp_ovr);
  assign last      = first ? (AVG_LOG2 == 0) : (cnt_q == LastCnt);
  assign avg_full  = win_sum >>> AVG_LOG2;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    win_ovr_d = win_ovr_q;
    result_d  = result_q;
    ovr_d     = ovr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    first     = 1'b0;
    add       = 1'b0;

    if (bus.clear_i) begin
      state_d   = StIdle;
      acc_d     = '0;
      cnt_d     = '0;
      win_ovr_d = 1'b0;
      result_d  = '0;
      ovr_d     = 1'b0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  first = bus.sample_valid_i;
        StAccum: add   = bus.sample_valid_i;
        StHold: begin
          if (bus.result_ready_i) begin
            valid_d = 1'b0;
            state_d = StIdle;
            first   = bus.sample_valid_i;
          end else if (bus.sample_valid_i) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (first || add) begin
        if (last) begin
          result_d  = SignedW'(avg_full);
          ovr_d     = win_ovr_n;
          valid_d   = 1'b1;
          state_d   = StHold;
          acc_d     = '0;
          cnt_d     = '0;
          win_ovr_d = 1'b0;
        end else begin
          acc_d     = win_sum;
          cnt_d     = first ? (AVG_LOG2 + 1)'(1) : cnt_q + 1'b1;
          win_ovr_d = win_ovr_n;
          state_d   = StAccum;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      win_ovr_q <= 1'b0;
      result_q  <= '0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      win_ovr_q <= win_ovr_d;
      result_q  <= result_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.result_valid_o = valid_q;
  assign bus.result_data_o  = result_q;
  assign bus.overrange_o    = ovr_q;
  assign bus.overrun_o      = overrun_q;
  assign bus.sample_cnt_o   = cnt_q;

`ifdef MEAS_MINMAX_EN
  meas_minmax_tracker #(
    .WIDTH (SignedW)
  ) u_minmax (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (bus.clear_i),
    .first_i      (first),
    .add_i        (add),
    .commit_i     (last),
    .sample_i     (smp),
    .result_min_o (bus.result_min_o),
    .result_max_o (bus.result_max_o)
  );
`endif

endmodule
